// File: rtl/nlf_enum_pkg.sv
// Shared definitions for the non-linear filter preimage enumerator.
//   nlf_enum_state_t : enumerator FSM states (IDLE, SCAN, DONE)
//   CRYPTO1_FC       : Crypto1 Fc filter truth table (5 inputs, bit x = f(x))
//   tt_width(n)      : truth-table width for an n-input function (2**n)
package nlf_enum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } nlf_enum_state_t;

    localparam logic [31:0] CRYPTO1_FC = 32'hEC57E80A;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/nlf_preimage_enum_lsb_find.sv
// Combinational lowest-set-bit encoder.
// Ports:
//   i_vec       in  WIDTH          vector to scan
//   o_index     out $clog2(WIDTH)  index of the lowest set bit (0 when i_vec is zero)
//   o_valid     out 1              at least one bit of i_vec is set
//   o_is_single out 1              exactly one bit of i_vec is set
module lsb_find #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         i_vec,
    output logic [$clog2(WIDTH)-1:0] o_index,
    output logic                     o_valid,
    output logic                     o_is_single
);
    localparam int IDX_W = $clog2(WIDTH);

    // Scanning downwards lets the lowest set bit be the last one written.
    always_comb begin
        o_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IDX_W'(i);
            end
        end
    end

    assign o_valid     = |i_vec;
    // Clearing the lowest set bit leaves zero only if it was the sole one.
    assign o_is_single = o_valid && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/nlf_preimage_enum.sv
// Preimage enumerator for an N_IN-input non-linear filter function given as
// a truth table FN. A request selects the target output bit; every input
// vector x with FN[x] == req_bit is then streamed in ascending order, one per
// accepted beat, followed by a one-cycle done pulse.
// Optional build macro: NLF_ENUM_COUNT_EN -- when defined, match_cnt reports
// the number of preimages for the last accepted request; otherwise it is 0.
// Ports:
//   CLK        in   1       clock, rising edge
//   RESETn     in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_bit    in   1       target output bit
//   req_ready  out  1       request can be accepted (IDLE)
//   abort      in   1       drop the current enumeration
//   out_valid  out  1       out_data holds a preimage
//   out_ready  in   1       consumer accepts out_data
//   out_data   out  N_IN    current preimage
//   out_last   out  1       out_data is the final preimage
//   done       out  1       one-cycle completion pulse
//   empty      out  1       qualifies done: no preimages existed
//   match_cnt  out  N_IN+1  preimage count of the accepted request
module nlf_preimage_enum
    import nlf_enum_pkg::*;
#(
    parameter int                        N_IN = 5,
    parameter logic [tt_width(N_IN)-1:0] FN   = (tt_width(N_IN))'(CRYPTO1_FC)
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            req_valid,
    input  logic            req_bit,
    output logic            req_ready,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_IN-1:0] out_data,
    output logic            out_last,
    output logic            done,
    output logic            empty,
    output logic [N_IN:0]   match_cnt
);
    localparam int TT_W = tt_width(N_IN);

    nlf_enum_state_t r_state;
    nlf_enum_state_t w_state_nxt;
    logic [TT_W-1:0] r_mask;
    logic [TT_W-1:0] w_sel;
    logic [TT_W-1:0] w_mask_clr;
    logic [N_IN-1:0] w_index;
    logic            w_any;
    logic            w_single;
    logic            w_accept;
    logic            w_beat;
    logic            r_empty;

    // Pending-preimage set: bit x set means x is still to be emitted.
    assign w_sel      = req_bit ? FN : ~FN;
    assign w_accept   = (r_state == IDLE) && req_valid;
    // Abort wins over a simultaneous handshake, so that beat is not consumed.
    assign w_beat     = (r_state == SCAN) && out_ready && !abort;
    assign w_mask_clr = r_mask & (r_mask - TT_W'(1));

    lsb_find #(
        .WIDTH(TT_W)
    ) u_lsb_find (
        .i_vec      (r_mask),
        .o_index    (w_index),
        .o_valid    (w_any),
        .o_is_single(w_single)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_sel == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (out_ready && w_single) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        out_valid = (r_state == SCAN) && w_any;
        out_last  = (r_state == SCAN) && w_single;
        done      = (r_state == DONE);
    end

    assign out_data = w_index;
    assign empty    = r_empty;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_mask <= '0;
        end else if (w_accept) begin
            r_mask <= w_sel;
        end else if (abort && (r_state != IDLE)) begin
            r_mask <= '0;
        end else if (w_beat) begin
            r_mask <= w_mask_clr;
        end
    end

    // empty is only meaningful alongside done; drop it when leaving DONE.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_empty <= 1'b0;
        end else if (w_accept) begin
            r_empty <= (w_sel == '0);
        end else if (r_state == DONE) begin
            r_empty <= 1'b0;
        end
    end

`ifdef NLF_ENUM_COUNT_EN
    function automatic logic [N_IN:0] popcount(input logic [TT_W-1:0] v);
        logic [N_IN:0] c;
        c = '0;
        for (int i = 0; i < TT_W; i++) begin
            c = c + (N_IN + 1)'(v[i]);
        end
        return c;
    endfunction

    logic [N_IN:0] r_match_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_match_cnt <= popcount(w_sel);
        end
    end

    assign match_cnt = r_match_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/nlf_preimage_enum.md
# nlf_preimage_enum

Parametrised preimage enumerator for an N-input non-linear filter function given as a truth table. A target output bit is accepted over a valid/ready request. The block then streams every input vector whose table entry equals that bit, in ascending order, one per cycle under output backpressure, and signals completion. It sits between the Crypto1 filter layer and the state-recovery search logic. It replaces the fixed 5-input, free-running Fc enumerator with a handshaked, abortable, width-generic block.

## Interface
- N_IN, 5: filter input count; legal 2..6.
- FN, 32'hEC57E80A: truth table, width 2**N_IN; bit x = f(x).
- CLK  in  1  clock, rising edge.
- RESETn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_bit  in  1  target output bit.
- req_ready  out  1  block can accept a request (IDLE only).
- abort  in  1  drop the current enumeration, return to IDLE.
- out_valid  out  1  out_data holds a preimage.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  N_IN  preimage x with FN[x]==req_bit.
- out_last  out  1  out_data is the final preimage.
- done  out  1  one-cycle pulse: enumeration finished.
- empty  out  1  qualifies done: zero preimages existed.
- match_cnt  out  N_IN+1  number of preimages for the accepted request.

## Operation
- Registers: state, mask[2**N_IN], match_cnt, empty.
- FSM states: IDLE, SCAN, DONE.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready: mask <= req_bit ? FN : ~FN.
  - Next state is SCAN if the mask is non-zero, otherwise DONE with empty<=1.
- SCAN
  - out_valid=1.
  - out_data = index of the lowest set bit of mask.
  - out_last = (mask & (mask-1))==0.
  - On out_valid&&out_ready: clear that bit of mask.
  - If out_last is also set on that handshake, next state is DONE.
- DONE
  - done=1 for exactly one cycle, then IDLE.
  - empty holds its value during the done pulse and clears on return to IDLE.
- abort
  - From SCAN or DONE: next state IDLE, mask<=0, no done pulse.
  - Ignored in IDLE.
  - Beats out_valid&&out_ready in the same cycle: that beat is not counted as consumed.
- Output order is strictly ascending x. Every preimage is presented exactly once.
- out_data and out_valid must remain stable while out_valid&&!out_ready.
- Outputs are functions of registers only. There is no combinational path from any input to any output.

## Timing
- Reset values:
  - state=IDLE, mask=0.
  - req_ready=1, out_valid=0, out_data=0, out_last=0.
  - done=0, empty=0, match_cnt=0.
- A request accepted at edge t gives first out_valid in the cycle after t.
- Throughput is one preimage per cycle when out_ready is held high.
- A full enumeration of K preimages without stalls: K SCAN cycles, one DONE cycle, then req_ready=1 again.
- Empty case: accept edge, one cycle DONE with done=1 and empty=1, then IDLE.
- req_valid is ignored outside IDLE. Requests are never queued.
- Reset asserted mid-enumeration clears all state immediately (asynchronous).

## Configuration
- NLF_ENUM_COUNT_EN defined:
  - match_cnt <= popcount(selected mask) at request acceptance.
  - Held until the next acceptance.
- NLF_ENUM_COUNT_EN undefined:
  - Popcount logic is not built.
  - match_cnt is tied to 0.
  - All other behaviour is identical.

## Structure
- Package nlf_enum_pkg holds:
  - state enum nlf_enum_state_t {IDLE, SCAN, DONE};
  - constant CRYPTO1_FC = 32'hEC57E80A;
  - function tt_width(n) = 2**n.
- Sub-module lsb_find(WIDTH): combinational lowest-set-bit encoder.
  - Outputs: index, valid, is_single (single bit set).
  - Instantiated once on mask.

## Test plan
- Defaults, req_bit=0, out_ready=1:
  - out_data sequence 0,2,4,5,6,7,8,9,10,12,19,21,23,24,25,28 on consecutive cycles.
  - out_last only on 28.
  - done the next cycle.
  - match_cnt=16 with macro.
- Defaults, req_bit=1, out_ready randomly toggled:
  - Sequence 1,3,11,13,14,15,16,17,18,20,22,26,27,29,30,31.
  - Data stable while stalled.
  - No drops or duplicates.
- FN=32'h0, req_bit=1:
  - No out_valid.
  - done=1 and empty=1 one cycle after acceptance.
  - match_cnt=0.
- N_IN=4, FN=16'h8001, req_bit=1:
  - Outputs 0, then 15 with out_last=1.
  - Second back-to-back request accepted the cycle after done.
- Defaults, req_bit=0, abort after third handshake:
  - Next cycle IDLE, req_ready=1.
  - No done pulse.
  - A new request restarts at 0.
- RESETn low mid-SCAN (after output 7):
  - All outputs at reset values immediately.
  - A subsequent request enumerates from 0.
